// File: rtl/aibcr3aux_osc_pkg.sv
// Shared definitions for the oscillator delay-chain monitor.
// Contents:
//   mon_state_e - FSM state encoding (IDLE/FLUSH/LAUNCH/WAIT/WIDTH/DONE)
//   exp_lat     - expected token latency through NUNIT two-flop delay units
//   flush_len   - number of cycles the chain is held at 0 before a launch
package aibcr3aux_osc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_LAUNCH,
      ST_WAIT,
      ST_WIDTH,
      ST_DONE
   } mon_state_e;

   // Each delay unit is two scan flops, so an ideal chain delays by 2*NUNIT cycles.
   function automatic int exp_lat(input int nunit);
      return 2 * nunit;
   endfunction

   // Two cycles beyond the chain depth guarantee that any stale token has drained.
   function automatic int flush_len(input int nunit);
      return 2 * nunit + 2;
   endfunction

endpackage

// File: rtl/aibcr3aux_osc_dly_mon_cnt.sv
// Saturating up-counter used by the delay monitor for flush timing and latency measurement.
// Ports:
//   cp      in  clock
//   rst     in  asynchronous active-high reset
//   clr     in  synchronous clear (has priority over en)
//   en      in  count enable
//   sat     in  saturation value; the counter never exceeds it
//   cnt     out current count
//   cnt_inc out value the counter takes if enabled this cycle (saturated)
module aibcr3aux_osc_dly_mon_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] sat,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] cnt_inc
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_inc = (cnt_q >= sat) ? sat : cnt_q + CNT_W'(1);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/aibcr3aux_osc_dly_mon.sv
// Monitor for a chain of NUNIT oscillator delay units (two scan flops each).
// Flushes the chain, launches a one-cycle token, measures its latency in cp cycles,
// checks the pulse width at the chain output and flags stuck-at chains.
// Ports:
//   cp          in  clock shared with the delay chain
//   rst         in  asynchronous active-high reset; aborts any measurement
//   start       in  one-cycle request, accepted only when idle
//   chain_q     in  q of the last delay unit
//   chain_d     out d of the first delay unit
//   busy        out measurement in progress
//   done        out one-cycle pulse when results update
//   pass        out lat equals the expected latency and no error flag set
//   lat         out measured latency, all-ones on timeout
//   err_stuck0  out token never arrived
//   err_stuck1  out chain_q high at the end of the flush
//   err_width   out chain_q high for more than one cycle
module aibcr3aux_osc_dly_mon
   import aibcr3aux_osc_pkg::*;
#(
   parameter int NUNIT = 8,
   parameter int CNT_W = 8,
   parameter int TMO   = 255
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             start,
   input  logic             chain_q,
   output logic             chain_d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] lat,
   output logic             err_stuck0,
   output logic             err_stuck1,
   output logic             err_width
);

   localparam int EXP_LAT   = exp_lat(NUNIT);
   localparam int FLUSH_LEN = flush_len(NUNIT);

   localparam logic [CNT_W-1:0] EXP_LAT_W    = CNT_W'(EXP_LAT);
   localparam logic [CNT_W-1:0] TMO_W        = CNT_W'(TMO);
   localparam logic [CNT_W-1:0] FLUSH_LAST_W = CNT_W'(FLUSH_LEN - 1);

   if ((TMO <= EXP_LAT) || (TMO > (2 ** CNT_W) - 1)) begin : g_param_err
      $error("aibcr3aux_osc_dly_mon: TMO must exceed 2*NUNIT and fit in CNT_W bits");
   end

   mon_state_e       state_d, state_q;
   logic             chain_d_d, chain_d_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;
   logic             pass_d, pass_q;
   logic [CNT_W-1:0] lat_d, lat_q;
   logic             err_stuck0_d, err_stuck0_q;
   logic             err_stuck1_d, err_stuck1_q;
   logic             err_width_d, err_width_q;

   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_val;
   logic [CNT_W-1:0] cnt_inc;

   aibcr3aux_osc_dly_mon_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .cp      (cp),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .sat     (TMO_W),
      .cnt     (cnt_val),
      .cnt_inc (cnt_inc)
   );

   // Next-state logic. chain_d is registered and set only on the transition into
   // LAUNCH, so the chain sees exactly one high cycle. In WAIT the latency is the
   // post-increment count, i.e. the number of cycles elapsed since LAUNCH.
   always_comb begin
      state_d      = state_q;
      chain_d_d    = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      lat_d        = lat_q;
      err_stuck0_d = err_stuck0_q;
      err_stuck1_d = err_stuck1_q;
      err_width_d  = err_width_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               lat_d        = '0;
               pass_d       = 1'b0;
               err_stuck0_d = 1'b0;
               err_stuck1_d = 1'b0;
               err_width_d  = 1'b0;
               busy_d       = 1'b1;
               cnt_clr      = 1'b1;
               state_d      = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (cnt_val == FLUSH_LAST_W) begin
               if (chain_q) begin
                  err_stuck1_d = 1'b1;
                  lat_d        = '0;
                  done_d       = 1'b1;
                  state_d      = ST_DONE;
               end else begin
                  chain_d_d = 1'b1;
                  cnt_clr   = 1'b1;
                  state_d   = ST_LAUNCH;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_en = 1'b1;
            if (chain_q) begin
               lat_d   = cnt_inc;
               state_d = ST_WIDTH;
            end else if (cnt_inc == TMO_W) begin
               err_stuck0_d = 1'b1;
               lat_d        = '1;
               done_d       = 1'b1;
               state_d      = ST_DONE;
            end
         end
         ST_WIDTH: begin
            if (chain_q) begin
               err_width_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // pass is evaluated from the values being committed so it is valid alongside done.
      if (state_d == ST_DONE) begin
         pass_d = (lat_d == EXP_LAT_W) && !(err_stuck0_d || err_stuck1_d || err_width_d);
      end
   end

   // State and registered outputs; reset aborts a measurement and clears all results.
   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         chain_d_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         lat_q        <= '0;
         err_stuck0_q <= 1'b0;
         err_stuck1_q <= 1'b0;
         err_width_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         chain_d_q    <= chain_d_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         lat_q        <= lat_d;
         err_stuck0_q <= err_stuck0_d;
         err_stuck1_q <= err_stuck1_d;
         err_width_q  <= err_width_d;
      end
   end

   assign chain_d    = chain_d_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign lat        = lat_q;
   assign err_stuck0 = err_stuck0_q;
   assign err_stuck1 = err_stuck1_q;
   assign err_width  = err_width_q;

endmodule

// File: tb/tb_aibcr3aux_osc_dly_mon.sv
// Self-checking bench for aibcr3aux_osc_dly_mon. The delay chain is modelled as a
// shift register of cp flops with optional extra depth, stuck-at outputs and a
// stretched output pulse. Expected results come from a cycle-count model of the
// measurement sequence (flush, launch, wait, width, done).
module tb_aibcr3aux_osc_dly_mon;

   localparam int NUNIT     = 8;
   localparam int CNT_W     = 8;
   localparam int TMO       = 255;
   localparam int EXP_LAT   = 2 * NUNIT;
   localparam int FLUSH_LEN = 2 * NUNIT + 2;

   logic             cp;
   logic             rst;
   logic             start;
   logic             chain_q;
   logic             chain_d;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] lat;
   logic             err_stuck0;
   logic             err_stuck1;
   logic             err_width;

   int checks   = 0;
   int failures = 0;

   // Chain model controls
   int   chainLen = EXP_LAT;
   bit   stuck0   = 1'b0;
   bit   stuck1   = 1'b0;
   bit   stretch  = 1'b0;
   logic [31:0] shiftReg;
   logic        lastPrev;
   logic        chainOut;
   int          doneCount;

   aibcr3aux_osc_dly_mon #(
      .NUNIT (NUNIT),
      .CNT_W (CNT_W),
      .TMO   (TMO)
   ) dut (
      .cp         (cp),
      .rst        (rst),
      .start      (start),
      .chain_q    (chain_q),
      .chain_d    (chain_d),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .lat        (lat),
      .err_stuck0 (err_stuck0),
      .err_stuck1 (err_stuck1),
      .err_width  (err_width)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   // Delay chain: chainLen cp flops; lastPrev lets the output be stretched by one cycle
   always @(posedge cp or posedge rst) begin
      if (rst) begin
         shiftReg <= '0;
         lastPrev <= 1'b0;
      end else begin
         shiftReg <= {shiftReg[30:0], chain_d};
         lastPrev <= shiftReg[chainLen-1];
      end
   end

   assign chainOut = shiftReg[chainLen-1] | (stretch & lastPrev);
   assign chain_q  = stuck1 ? 1'b1 : (stuck0 ? 1'b0 : chainOut);

   // Count done pulses sampled away from the active edge
   always @(negedge cp) begin
      if (done) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One measurement: predict the outcome from the chain fault settings, run it and compare.
   // extraStartAt pulses start again at that busy cycle; pokeDone pulses start in the DONE cycle.
   task automatic applyStimulus(input string name, input int len, input bit s0, input bit s1,
                                input bit st, input int extraStartAt, input bit pokeDone);
      int expCycles, expLat, expLaunch, cycles, launchSeen;
      bit expE0, expE1, expEw, expPass;

      chainLen = len;
      stuck0   = s0;
      stuck1   = s1;
      stretch  = st;

      expE0 = 1'b0; expE1 = 1'b0; expEw = 1'b0;
      if (s1) begin
         expE1 = 1'b1; expLat = 0; expLaunch = 0;
         expCycles = FLUSH_LEN + 1;
      end else if (s0 || len >= TMO) begin
         expE0 = 1'b1; expLat = 255; expLaunch = 1;
         expCycles = FLUSH_LEN + 1 + TMO + 1;
      end else begin
         expLat = len; expLaunch = 1; expEw = st;
         expCycles = FLUSH_LEN + 1 + len + 1 + 1;
      end
      expPass = (expLat == EXP_LAT) && !expE0 && !expE1 && !expEw;

      @(negedge cp);
      start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      cycles = 1;
      launchSeen = 0;
      checkOutput({name, ":busy"}, 32'(busy), 32'd1);
      while (!done && cycles < 600) begin
         if (chain_d) launchSeen++;
         @(negedge cp);
         cycles++;
         start = (cycles == extraStartAt);
      end
      start = 1'b0;
      checkOutput({name, ":done_seen"}, 32'(done), 32'd1);
      checkOutput({name, ":cycles"}, 32'(cycles), 32'(expCycles));
      checkOutput({name, ":launch"}, 32'(launchSeen), 32'(expLaunch));
      checkOutput({name, ":lat"}, 32'(lat), 32'(expLat));
      checkOutput({name, ":pass"}, 32'(pass), 32'(expPass));
      checkOutput({name, ":err_stuck0"}, 32'(err_stuck0), 32'(expE0));
      checkOutput({name, ":err_stuck1"}, 32'(err_stuck1), 32'(expE1));
      checkOutput({name, ":err_width"}, 32'(err_width), 32'(expEw));

      start = pokeDone;
      @(negedge cp);
      start = 1'b0;
      checkOutput({name, ":done_pulse"}, 32'(done), 32'd0);
      repeat (3) @(negedge cp);
      checkOutput({name, ":busy_idle"}, 32'(busy), 32'd0);
      checkOutput({name, ":lat_hold"}, 32'(lat), 32'(expLat));
      checkOutput({name, ":pass_hold"}, 32'(pass), 32'(expPass));
   endtask

   initial begin
      start     = 1'b0;
      doneCount = 0;
      rst       = 1'b1;
      #1;
      checkOutput("reset:chain_d", 32'(chain_d), 32'd0);
      checkOutput("reset:busy", 32'(busy), 32'd0);
      checkOutput("reset:done", 32'(done), 32'd0);
      checkOutput("reset:pass", 32'(pass), 32'd0);
      checkOutput("reset:lat", 32'(lat), 32'd0);
      checkOutput("reset:errs", 32'({err_stuck0, err_stuck1, err_width}), 32'd0);
      #20;
      @(negedge cp);
      rst = 1'b0;
      repeat (2) @(negedge cp);

      // Directed scenarios
      applyStimulus("ideal",   EXP_LAT,     1'b0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus("extra",   EXP_LAT + 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus("stuck0",  EXP_LAT,     1'b1, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus("stuck1",  EXP_LAT,     1'b0, 1'b1, 1'b0, 0, 1'b0);
      applyStimulus("stretch", EXP_LAT,     1'b0, 1'b0, 1'b1, 0, 1'b0);

      // Randomized chains: extra depth 0..3, occasional stretch or stuck faults
      for (int i = 0; i < 10; i++) begin
         int kind;
         kind = int'($urandom_range(0, 5));
         repeat ($urandom_range(0, 4)) @(negedge cp);
         applyStimulus($sformatf("rand%0d", i), EXP_LAT + int'($urandom_range(0, 3)),
                       kind == 4, kind == 5, kind == 3, 0, 1'b0);
      end

      // Reset asserted in WAIT aborts asynchronously and clears everything
      chainLen = EXP_LAT; stuck0 = 1'b0; stuck1 = 1'b0; stretch = 1'b0;
      @(negedge cp);
      start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      repeat (FLUSH_LEN + 5) @(negedge cp);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort:busy", 32'(busy), 32'd0);
      checkOutput("abort:chain_d", 32'(chain_d), 32'd0);
      checkOutput("abort:results", 32'({done, pass, lat, err_stuck0, err_stuck1, err_width}), 32'd0);
      @(negedge cp);
      rst = 1'b0;
      repeat (2) @(negedge cp);

      // start while busy (mid-run and in the DONE cycle) must be ignored
      doneCount = 0;
      applyStimulus("ignore", EXP_LAT, 1'b0, 1'b0, 1'b0, 6, 1'b1);
      repeat (60) @(negedge cp);
      checkOutput("ignore:done_count", 32'(doneCount), 32'd1);
      checkOutput("ignore:busy_after", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
